// File: rtl/fifo_wr_arbiter_if.sv
// Request/ack and FIFO write-port bundle shared by the two requesters and the arbiter.
// The master side drives requests and the FIFO full flag; the slave side is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    RQ0_VLD;
  logic                    RQ0_LEN;
  logic [2*DATA_WIDTH-1:0] RQ0_DATA;
  logic                    RQ0_ACK;
  logic                    RQ1_VLD;
  logic                    RQ1_LEN;
  logic [2*DATA_WIDTH-1:0] RQ1_DATA;
  logic                    RQ1_ACK;
  logic                    W_FULL;
  logic                    W_INC;
  logic [DATA_WIDTH-1:0]   WR_DATA;
  logic                    BUSY;

  modport master (
    output RQ0_VLD, RQ0_LEN, RQ0_DATA, RQ1_VLD, RQ1_LEN, RQ1_DATA, W_FULL,
    input  RQ0_ACK, RQ1_ACK, W_INC, WR_DATA, BUSY
  );

  modport slave (
    input  RQ0_VLD, RQ0_LEN, RQ0_DATA, RQ1_VLD, RQ1_LEN, RQ1_DATA, W_FULL,
    output RQ0_ACK, RQ1_ACK, W_INC, WR_DATA, BUSY
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that serialises 1- or 2-byte requests from two requesters
// onto a single FIFO write port, stalling on W_FULL without losing or repeating bytes.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input logic               W_CLK,
  input logic               W_RST,
  fifo_wr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    grant_q, grant_d;   // requester granted most recently; also owns the current transaction
  logic                    len_q, len_d;
  logic [2*DATA_WIDTH-1:0] data_q, data_d;

  logic                    any_vld_s;
  logic                    grant_sel_s;
  logic                    w_inc_s;
  logic                    last_byte_s;
  logic [DATA_WIDTH-1:0]   wr_data_s;

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    any_vld_s   = bus.RQ0_VLD | bus.RQ1_VLD;
    grant_sel_s = 1'b0;
    if (bus.RQ0_VLD && bus.RQ1_VLD) begin
      grant_sel_s = ~grant_q;
    end else if (bus.RQ0_VLD) begin
      grant_sel_s = 1'b0;
    end else begin
      grant_sel_s = 1'b1;
    end
  end

  // Write strobe, final-byte detection and write-data mux.
  always_comb begin
    w_inc_s     = ((state_q == BYTE0) || (state_q == BYTE1)) && !bus.W_FULL;
    last_byte_s = w_inc_s && (((state_q == BYTE0) && !len_q) || (state_q == BYTE1));
    wr_data_s   = {DATA_WIDTH{1'b0}};
    case (state_q)
      BYTE0:   wr_data_s = data_q[DATA_WIDTH-1:0];
      BYTE1:   wr_data_s = data_q[2*DATA_WIDTH-1:DATA_WIDTH];
      IDLE:    wr_data_s = {DATA_WIDTH{1'b0}};
      default: wr_data_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // Next-state logic; requester inputs are only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    len_d   = len_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (any_vld_s) begin
          state_d = BYTE0;
          grant_d = grant_sel_s;
          len_d   = grant_sel_s ? bus.RQ1_LEN  : bus.RQ0_LEN;
          data_d  = grant_sel_s ? bus.RQ1_DATA : bus.RQ0_DATA;
        end else begin
          state_d = IDLE;
        end
      end
      BYTE0: begin
        if (w_inc_s) begin
          state_d = len_q ? BYTE1 : IDLE;
        end else begin
          state_d = BYTE0;
        end
      end
      BYTE1: begin
        if (w_inc_s) begin
          state_d = IDLE;
        end else begin
          state_d = BYTE1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset points the grant at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      len_q   <= 1'b0;
      data_q  <= {(2*DATA_WIDTH){1'b0}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      data_q  <= data_d;
    end
  end

  assign bus.W_INC   = w_inc_s;
  assign bus.WR_DATA = wr_data_s;
  assign bus.RQ0_ACK = last_byte_s & ~grant_q;
  assign bus.RQ1_ACK = last_byte_s &  grant_q;
  assign bus.BUSY    = (state_q != IDLE);

  fifo_wr_arbiter_chk u_chk (
    .W_CLK  (W_CLK),
    .W_RST  (W_RST),
    .w_inc  (bus.W_INC),
    .busy   (bus.BUSY),
    .ack0   (bus.RQ0_ACK),
    .ack1   (bus.RQ1_ACK)
  );

endmodule

// Invariants of the write port: strobes only while busy, acks only with a strobe, never two acks.
module fifo_wr_arbiter_chk (
  input logic W_CLK,
  input logic W_RST,
  input logic w_inc,
  input logic busy,
  input logic ack0,
  input logic ack1
);
  a_inc_busy: assert property (@(posedge W_CLK) disable iff (!W_RST) w_inc |-> busy);
  a_ack_inc:  assert property (@(posedge W_CLK) disable iff (!W_RST) (ack0 || ack1) |-> w_inc);
  a_one_ack:  assert property (@(posedge W_CLK) disable iff (!W_RST) !(ack0 && ack1));
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: inputs change 1 ns after the rising edge,
// outputs are checked at the falling edge.
module tb_fifo_wr_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fifo_wr_arbiter_if #(.DATA_WIDTH(8)) bus ();

  fifo_wr_arbiter #(.DATA_WIDTH(8)) dut (
    .W_CLK (clk),
    .W_RST (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic clear_inputs();
    bus.RQ0_VLD  = 1'b0;
    bus.RQ0_LEN  = 1'b0;
    bus.RQ0_DATA = 16'h0000;
    bus.RQ1_VLD  = 1'b0;
    bus.RQ1_LEN  = 1'b0;
    bus.RQ1_DATA = 16'h0000;
    bus.W_FULL   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      bus.RQ0_VLD  = 1'($urandom_range(1, 0));
      bus.RQ0_LEN  = 1'($urandom_range(1, 0));
      bus.RQ0_DATA = 16'($urandom);
      bus.RQ1_VLD  = 1'($urandom_range(1, 0));
      bus.RQ1_LEN  = 1'($urandom_range(1, 0));
      bus.RQ1_DATA = 16'($urandom);
      bus.W_FULL   = 1'($urandom_range(1, 0));
      settle();
      checks++;
      if (bus.W_INC !== 1'b0) begin
        failures++; $display("FAIL reset_w_inc: got %b want 0", bus.W_INC);
      end
      checks++;
      if (bus.WR_DATA !== 8'h00) begin
        failures++; $display("FAIL reset_wr_data: got %h want 00", bus.WR_DATA);
      end
      checks++;
      if ({bus.RQ0_ACK, bus.RQ1_ACK} !== 2'b00) begin
        failures++; $display("FAIL reset_acks: got %b want 00", {bus.RQ0_ACK, bus.RQ1_ACK});
      end
      checks++;
      if (bus.BUSY !== 1'b0) begin
        failures++; $display("FAIL reset_busy: got %b want 0", bus.BUSY);
      end
    end
    step();
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_one_byte();
    step();
    bus.RQ0_VLD  = 1'b1;
    bus.RQ0_LEN  = 1'b0;
    bus.RQ0_DATA = 16'h00A5;
    settle();
    checks++;
    if (bus.BUSY !== 1'b0) begin
      failures++; $display("FAIL one_idle_busy: got %b want 0", bus.BUSY);
    end
    step();
    bus.RQ0_VLD  = 1'b0;
    bus.RQ0_DATA = 16'hFFFF;
    settle();
    checks++;
    if (bus.W_INC !== 1'b1) begin
      failures++; $display("FAIL one_w_inc: got %b want 1", bus.W_INC);
    end
    checks++;
    if (bus.WR_DATA !== 8'hA5) begin
      failures++; $display("FAIL one_wr_data: got %h want a5", bus.WR_DATA);
    end
    checks++;
    if ({bus.RQ0_ACK, bus.RQ1_ACK} !== 2'b10) begin
      failures++; $display("FAIL one_acks: got %b want 10", {bus.RQ0_ACK, bus.RQ1_ACK});
    end
    step();
    settle();
    checks++;
    if ({bus.BUSY, bus.W_INC} !== 2'b00) begin
      failures++; $display("FAIL one_done: busy,w_inc got %b want 00", {bus.BUSY, bus.W_INC});
    end
  endtask

  task automatic test_two_byte();
    step();
    bus.RQ1_VLD  = 1'b1;
    bus.RQ1_LEN  = 1'b1;
    bus.RQ1_DATA = 16'h1234;
    step();
    bus.RQ1_VLD  = 1'b0;
    bus.RQ1_LEN  = 1'b0;
    bus.RQ1_DATA = 16'hFFFF;
    settle();
    checks++;
    if ({bus.W_INC, bus.WR_DATA} !== 9'h134) begin
      failures++; $display("FAIL two_byte0: w_inc,data got %h want 134", {bus.W_INC, bus.WR_DATA});
    end
    checks++;
    if ({bus.RQ0_ACK, bus.RQ1_ACK} !== 2'b00) begin
      failures++; $display("FAIL two_byte0_acks: got %b want 00", {bus.RQ0_ACK, bus.RQ1_ACK});
    end
    step();
    settle();
    checks++;
    if ({bus.W_INC, bus.WR_DATA} !== 9'h112) begin
      failures++; $display("FAIL two_byte1: w_inc,data got %h want 112", {bus.W_INC, bus.WR_DATA});
    end
    checks++;
    if ({bus.RQ0_ACK, bus.RQ1_ACK} !== 2'b01) begin
      failures++; $display("FAIL two_byte1_acks: got %b want 01", {bus.RQ0_ACK, bus.RQ1_ACK});
    end
    step();
    settle();
    checks++;
    if (bus.BUSY !== 1'b0) begin
      failures++; $display("FAIL two_done_busy: got %b want 0", bus.BUSY);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] got_d [4];
    logic [1:0] got_a [4];
    logic [7:0] exp_d;
    logic [1:0] exp_a;
    int n;
    n = 0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.RQ0_VLD  = 1'b1;
    bus.RQ0_DATA = 16'h0011;
    bus.RQ1_VLD  = 1'b1;
    bus.RQ1_DATA = 16'h0022;
    for (int c = 0; c < 20 && n < 4; c++) begin
      step();
      settle();
      if (bus.W_INC === 1'b1) begin
        got_d[n] = bus.WR_DATA;
        got_a[n] = {bus.RQ0_ACK, bus.RQ1_ACK};
        n++;
      end
    end
    checks++;
    if (n !== 4) begin
      failures++; $display("FAIL rr_count: got %0d writes want 4", n);
    end
    for (int i = 0; i < n; i++) begin
      exp_d = (i % 2 == 0) ? 8'h11 : 8'h22;
      exp_a = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if (got_d[i] !== exp_d || got_a[i] !== exp_a) begin
        failures++;
        $display("FAIL rr_write%0d: data,acks got %h,%b want %h,%b", i, got_d[i], got_a[i], exp_d, exp_a);
      end
    end
    step();
    clear_inputs();
  endtask

  task automatic test_full_stall();
    step();
    bus.RQ0_VLD  = 1'b1;
    bus.RQ0_LEN  = 1'b1;
    bus.RQ0_DATA = 16'hBEEF;
    step();
    bus.RQ0_VLD  = 1'b0;
    bus.RQ0_DATA = 16'h0000;
    settle();
    checks++;
    if ({bus.W_INC, bus.WR_DATA, bus.RQ0_ACK} !== 10'b1_11101111_0) begin
      failures++; $display("FAIL stall_byte0: w_inc,data,ack0 got %b want 1_11101111_0", {bus.W_INC, bus.WR_DATA, bus.RQ0_ACK});
    end
    step();
    bus.W_FULL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if ({bus.W_INC, bus.WR_DATA} !== 9'h0BE || {bus.RQ0_ACK, bus.RQ1_ACK} !== 2'b00 || bus.BUSY !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold%0d: w_inc,data got %h acks %b busy %b want 0be 00 1", i, {bus.W_INC, bus.WR_DATA}, {bus.RQ0_ACK, bus.RQ1_ACK}, bus.BUSY);
      end
      step();
    end
    bus.W_FULL = 1'b0;
    settle();
    checks++;
    if ({bus.W_INC, bus.WR_DATA} !== 9'h1BE || {bus.RQ0_ACK, bus.RQ1_ACK} !== 2'b10) begin
      failures++; $display("FAIL stall_release: w_inc,data got %h acks %b want 1be 10", {bus.W_INC, bus.WR_DATA}, {bus.RQ0_ACK, bus.RQ1_ACK});
    end
    step();
    settle();
    checks++;
    if ({bus.BUSY, bus.W_INC} !== 2'b00) begin
      failures++; $display("FAIL stall_done: busy,w_inc got %b want 00", {bus.BUSY, bus.W_INC});
    end
  endtask

  task automatic test_reset_mid();
    step();
    bus.RQ0_VLD  = 1'b1;
    bus.RQ0_LEN  = 1'b1;
    bus.RQ0_DATA = 16'h5678;
    step();
    clear_inputs();
    settle();
    checks++;
    if ({bus.W_INC, bus.WR_DATA} !== 9'h178) begin
      failures++; $display("FAIL rstmid_byte0: w_inc,data got %h want 178", {bus.W_INC, bus.WR_DATA});
    end
    step();
    rst_n = 1'b0;
    settle();
    checks++;
    if ({bus.BUSY, bus.W_INC, bus.RQ0_ACK, bus.RQ1_ACK} !== 4'b0000 || bus.WR_DATA !== 8'h00) begin
      failures++; $display("FAIL rstmid_abort: busy,w_inc,acks got %b data %h want 0000 00", {bus.BUSY, bus.W_INC, bus.RQ0_ACK, bus.RQ1_ACK}, bus.WR_DATA);
    end
    bus.RQ0_VLD  = 1'b1;
    bus.RQ0_DATA = 16'h0033;
    bus.RQ1_VLD  = 1'b1;
    bus.RQ1_DATA = 16'h0044;
    step();
    rst_n = 1'b1;
    step();
    settle();
    checks++;
    if ({bus.W_INC, bus.WR_DATA} !== 9'h133 || {bus.RQ0_ACK, bus.RQ1_ACK} !== 2'b10) begin
      failures++; $display("FAIL rstmid_first_grant: w_inc,data got %h acks %b want 133 10", {bus.W_INC, bus.WR_DATA}, {bus.RQ0_ACK, bus.RQ1_ACK});
    end
    step();
    clear_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clear_inputs();
    test_reset();
    test_one_byte();
    test_two_byte();
    test_round_robin();
    test_full_stall();
    test_reset_mid();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
